reset_seq_gen: RTL and testbench
================================

# reset_seq_gen

Reset sequencer that generates the chip's staged active-low reset outputs: a minimum-width reset on power-on, software request or watchdog expiry, followed by an ordered stage-by-stage release. It sits upstream of the per-domain async-assert/sync-deassert reset synchronisers and drives their `resetn` inputs. It also records the cause of the most recent reset.

## Interface
- `ASSERT_CYCLES`, 16: minimum cycles all outputs are held low after reset entry (≥1)
- `STAGES`, 3: number of staged reset outputs (≥1)
- `STAGE_GAP`, 4: cycles between consecutive stage releases (≥1)
- `CNT_W`, 8: sequence counter width; requires ASSERT_CYCLES + STAGE_GAP*(STAGES-1) < 2^CNT_W
- `WDOG_TIMEOUT`, 1000: watchdog timeout in cycles (only with `RSTGEN_WDOG_EN`)
- `clk`  in  1  system clock
- `resetn`  in  1  power-on reset, asynchronous, active-low
- `scan_bypass`  in  1  test mode; outputs follow `resetn` directly
- `sw_rst_req`  in  1  synchronous software reset request, level-sensitive
- `wdog_enable`  in  1  watchdog enable (only with `RSTGEN_WDOG_EN`)
- `wdog_kick`  in  1  watchdog restart pulse (only with `RSTGEN_WDOG_EN`)
- `rst_out_n`  out  STAGES  staged resets, active-low; bit 0 releases first
- `busy`  out  1  high while the sequence is not complete
- `rst_cause`  out  2  00 = POR, 01 = SW, 10 = WDOG, 11 = unused

## Operation
- FSM states: ASSERT, RELEASE, RUN. `resetn` low asynchronously forces ASSERT, counter = 0, `rst_out_n` = 0, `busy` = 1, `rst_cause` = 00.
- ASSERT: counter increments every cycle and all outputs stay low. When the counter reaches ASSERT_CYCLES, go to RELEASE.
- RELEASE: counter keeps incrementing. Bit i of `rst_out_n` is set when the counter reaches ASSERT_CYCLES + STAGE_GAP*i. Released bits stay high. After the last bit is released, go to RUN; the counter holds.
- RUN: `busy` = 0. A request (`sw_rst_req`, or watchdog expiry) enters ASSERT with counter = 0 and all `rst_out_n` cleared.
- A request in ASSERT or RELEASE restarts ASSERT with counter = 0. Any already-released bits are re-asserted low. A held request therefore keeps reset asserted indefinitely.
- Simultaneous SW and WDOG requests give cause 10 (WDOG has priority). `rst_cause` updates only on request acceptance or POR, and holds otherwise.
- When `scan_bypass` = 1: `rst_out_n` = {STAGES{`resetn`}}, purely combinational. The FSM still runs internally.
- All `rst_out_n` bits are driven from flops (glitch-free), except in scan bypass.

## Timing
- Edge count starts at the first rising `clk` edge sampling `resetn` high, which is edge 1.
- `rst_out_n[i]` rises at edge ASSERT_CYCLES + STAGE_GAP*i. `busy` falls on the same edge as the last stage.
- Defaults: bit0 at edge 16, bit1 at edge 20, bit2 at edge 24, `busy` low at edge 24.
- Request sampled high at edge N in RUN: after edge N, all `rst_out_n` = 0, `busy` = 1 and `rst_cause` is updated. Bit i then rises at edge N + ASSERT_CYCLES + STAGE_GAP*i.
- `resetn` assertion mid-sequence affects outputs immediately, with no clock required.

## Configuration
- `RSTGEN_WDOG_EN` defined:
  - Adds `wdog_enable`, `wdog_kick` and the `WDOG_TIMEOUT` parameter.
  - A watchdog counter counts in RUN while `wdog_enable` = 1.
  - The counter clears on `wdog_kick`, on `wdog_enable` = 0, outside RUN, and on `resetn`.
  - Reaching WDOG_TIMEOUT-1 raises a one-cycle internal request, with cause 10.
- Undefined: no watchdog ports or logic; `rst_cause` is never 10.

## Test plan
- POR with defaults, `resetn` released → `rst_out_n` goes 000, then 001 at edge 16, 011 at edge 20, 111 at edge 24; `busy` falls at edge 24; `rst_cause` = 00.
- `sw_rst_req` pulsed 1 cycle at edge N in RUN → `rst_out_n` = 000 after N; release at N+16/N+20/N+24; `rst_cause` = 01.
- `sw_rst_req` pulsed during RELEASE when `rst_out_n` = 011 → returns to 000 next cycle; the full 16+4+4 sequence restarts.
- `resetn` driven low between clock edges mid-RELEASE → `rst_out_n` = 000 and `rst_cause` = 00 immediately; `busy` = 1.
- `scan_bypass` = 1 while toggling `resetn` → `rst_out_n` = 111 or 000 tracking `resetn` with zero cycles of latency.
- With `RSTGEN_WDOG_EN` and `WDOG_TIMEOUT` = 50, `wdog_enable` = 1, no kick → reset entered 50 cycles after RUN, `rst_cause` = 10. Kicking every 40 cycles → no reset.

Source files
------------

// File: rtl/reset_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : reset_seq_gen
// Brief    : Staged active-low reset sequencer with min-width assertion,
//            ordered release and reset-cause capture. Optional watchdog
//            enabled by defining RSTGEN_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reset_seq_gen #(
    parameter int ASSERT_CYCLES = 16,
    parameter int STAGES        = 3,
    parameter int STAGE_GAP     = 4,
    parameter int CNT_W         = 8
`ifdef RSTGEN_WDOG_EN
    ,
    parameter int WDOG_TIMEOUT  = 1000
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              scan_bypass,
    input  logic              sw_rst_req,
`ifdef RSTGEN_WDOG_EN
    input  logic              wdog_enable,
    input  logic              wdog_kick,
`endif
    output logic [STAGES-1:0] rst_out_n,
    output logic              busy,
    output logic [1:0]        rst_cause
);

    localparam logic [1:0] c_ASSERT  = 2'd0;
    localparam logic [1:0] c_RELEASE = 2'd1;
    localparam logic [1:0] c_RUN     = 2'd2;

    localparam logic [1:0] c_CAUSE_POR  = 2'b00;
    localparam logic [1:0] c_CAUSE_SW   = 2'b01;
    localparam logic [1:0] c_CAUSE_WDOG = 2'b10;

    localparam logic [CNT_W-1:0] c_FIRST = CNT_W'(ASSERT_CYCLES);
    localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(ASSERT_CYCLES + STAGE_GAP * (STAGES - 1));

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [STAGES-1:0] r_out_n;
    logic              r_busy;
    logic [1:0]        r_cause;

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [STAGES-1:0] w_out_nxt;
    logic              w_busy_nxt;
    logic [1:0]        w_cause_nxt;
    logic [STAGES-1:0] w_hit;
    logic              w_wdog_req;
    logic              w_req;

    assign w_cnt_inc = r_cnt + 1'b1;

    // Stage i is due once the incremented count reaches its release point.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int c_THR = ASSERT_CYCLES + STAGE_GAP * gi;
        assign w_hit[gi] = (w_cnt_inc >= CNT_W'(c_THR));
    end

`ifdef RSTGEN_WDOG_EN
    localparam int c_WD_W = $clog2(WDOG_TIMEOUT) + 1;

    logic [c_WD_W-1:0] r_wd_cnt;

    assign w_wdog_req = (r_state == c_RUN) && wdog_enable && !wdog_kick &&
                        (r_wd_cnt == c_WD_W'(WDOG_TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wd_cnt <= '0;
        end else if ((r_state != c_RUN) || !wdog_enable || wdog_kick || w_wdog_req) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end
`else
    assign w_wdog_req = 1'b0;
`endif

    assign w_req = sw_rst_req | w_wdog_req;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out_n;
        w_busy_nxt  = r_busy;
        w_cause_nxt = r_cause;
        if (w_req) begin
            // Any request, in any state, restarts the full sequence.
            w_state_nxt = c_ASSERT;
            w_cnt_nxt   = '0;
            w_out_nxt   = '0;
            w_busy_nxt  = 1'b1;
            w_cause_nxt = w_wdog_req ? c_CAUSE_WDOG : c_CAUSE_SW;
        end else begin
            case (r_state)
                c_ASSERT, c_RELEASE: begin
                    w_cnt_nxt = w_cnt_inc;
                    w_out_nxt = r_out_n | w_hit;
                    if (w_cnt_inc == c_LAST) begin
                        w_state_nxt = c_RUN;
                        w_busy_nxt  = 1'b0;
                    end else if (w_cnt_inc == c_FIRST) begin
                        w_state_nxt = c_RELEASE;
                    end
                end
                c_RUN: begin
                    w_busy_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = c_ASSERT;
                    w_cnt_nxt   = '0;
                    w_out_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_ASSERT;
            r_cnt   <= '0;
            r_out_n <= '0;
            r_busy  <= 1'b1;
            r_cause <= c_CAUSE_POR;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out_n <= w_out_nxt;
            r_busy  <= w_busy_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    assign rst_out_n = scan_bypass ? {STAGES{resetn}} : r_out_n;
    assign busy      = r_busy;
    assign rst_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_reset_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_seq_gen
// Brief    : Directed scoreboard bench for reset_seq_gen (3 stages, defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_seq_gen;

    logic       clk = 1'b0;
    logic       resetn;
    logic       scan_bypass;
    logic       sw_rst_req;
    logic [2:0] rst_out_n;
    logic       busy;
    logic [1:0] rst_cause;
`ifdef RSTGEN_WDOG_EN
    logic       wdog_enable;
    logic       wdog_kick;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       busy;
        logic [1:0] cause;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

`ifdef RSTGEN_WDOG_EN
    reset_seq_gen #(
        .ASSERT_CYCLES(16), .STAGES(3), .STAGE_GAP(4), .CNT_W(8), .WDOG_TIMEOUT(50)
    ) dut (
        .clk(clk), .resetn(resetn), .scan_bypass(scan_bypass), .sw_rst_req(sw_rst_req),
        .wdog_enable(wdog_enable), .wdog_kick(wdog_kick),
        .rst_out_n(rst_out_n), .busy(busy), .rst_cause(rst_cause)
    );
`else
    reset_seq_gen #(
        .ASSERT_CYCLES(16), .STAGES(3), .STAGE_GAP(4), .CNT_W(8)
    ) dut (
        .clk(clk), .resetn(resetn), .scan_bypass(scan_bypass), .sw_rst_req(sw_rst_req),
        .rst_out_n(rst_out_n), .busy(busy), .rst_cause(rst_cause)
    );
`endif

    // Edge numbering: edge 1 is the first rising edge sampling resetn high.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_pt(input int c, input logic [2:0] r, input logic b, input logic [1:0] ca);
        exp_t e;
        e.cyc = c; e.rst = r; e.busy = b; e.cause = ca;
        q.push_back(e);
    endtask

    // Expected snapshots of a sequence that restarted at edge base.
    task automatic push_seq(input int base, input logic [1:0] ca, input int upto);
        int offs[10] = '{0, 1, 15, 16, 19, 20, 21, 23, 24, 30};
        foreach (offs[k]) begin
            if (offs[k] <= upto)
                push_pt(base + offs[k], {offs[k] >= 24, offs[k] >= 20, offs[k] >= 16},
                        offs[k] < 24, ca);
        end
    endtask

    task automatic drain(input int t, input bit all);
        exp_t e;
        int   guard = 0;
        forever begin
            while (q.size() != 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc < cyc) begin
                    chk("missed_edge", cyc, e.cyc);
                end else begin
                    chk("rst_out_n", {29'd0, rst_out_n}, {29'd0, e.rst});
                    chk("busy", {31'd0, busy}, {31'd0, e.busy});
                    chk("rst_cause", {30'd0, rst_cause}, {30'd0, e.cause});
                end
            end
            if (all && q.size() == 0) break;
            if (!all && cyc >= t) break;
            if (guard > 2000) begin
                bad++;
                $display("FAIL drain_timeout: edge=%0d pending=%0d", cyc, q.size());
                q.delete();
                break;
            end
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic sw_pulse(input int upto);
        sw_rst_req = 1'b1;
        push_seq(cyc + 1, 2'b01, upto);
        @(posedge clk); #1;
        sw_rst_req = 1'b0;
        drain(0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        resetn      = 1'b0;
        scan_bypass = 1'b0;
        sw_rst_req  = 1'b0;
`ifdef RSTGEN_WDOG_EN
        wdog_enable = 1'b0;
        wdog_kick   = 1'b0;
`endif
        #27;
        chk("por_rst_out_n", {29'd0, rst_out_n}, 32'h0);
        chk("por_busy", {31'd0, busy}, 32'h1);
        chk("por_cause", {30'd0, rst_cause}, 32'h0);

        // POR release and full staged sequence
        @(negedge clk); resetn = 1'b1;
        push_seq(0, 2'b00, 30);
        drain(0, 1'b1);

        // Single-cycle software request from RUN
        sw_pulse(30);

        // Request during RELEASE with rst_out_n = 011 restarts everything
        sw_pulse(21);
        sw_pulse(30);

        // Held request keeps reset asserted
        sw_rst_req = 1'b1;
        c = cyc;
        for (int k = 1; k < 20; k++) push_pt(c + k, 3'b000, 1'b1, 2'b01);
        push_seq(c + 20, 2'b01, 30);
        drain(c + 20, 1'b0);
        sw_rst_req = 1'b0;
        drain(0, 1'b1);

        // Asynchronous resetn assertion mid-RELEASE
        sw_pulse(21);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_out_n", {29'd0, rst_out_n}, 32'h0);
        chk("async_busy", {31'd0, busy}, 32'h1);
        chk("async_cause", {30'd0, rst_cause}, 32'h0);
        @(negedge clk); resetn = 1'b1;
        push_seq(0, 2'b00, 30);
        drain(0, 1'b1);

        // Scan bypass: outputs track resetn combinationally
        scan_bypass = 1'b1;
        #1 chk("scan_hi_run", {29'd0, rst_out_n}, 32'h7);
        resetn = 1'b0;
        #1 chk("scan_lo", {29'd0, rst_out_n}, 32'h0);
        chk("scan_busy", {31'd0, busy}, 32'h1);
        resetn = 1'b1;
        #1 chk("scan_hi_assert", {29'd0, rst_out_n}, 32'h7);
        resetn = 1'b0;
        #1 chk("scan_lo2", {29'd0, rst_out_n}, 32'h0);
        scan_bypass = 1'b0;
        #1 chk("scan_off", {29'd0, rst_out_n}, 32'h0);
        @(negedge clk); resetn = 1'b1;
        push_seq(0, 2'b00, 30);
        drain(0, 1'b1);

`ifdef RSTGEN_WDOG_EN
        // Watchdog expiry 50 cycles after enabling in RUN
        wdog_enable = 1'b1;
        push_pt(cyc + 49, 3'b111, 1'b0, 2'b00);
        push_seq(cyc + 50, 2'b10, 30);
        drain(0, 1'b1);
        // Regular kicks prevent expiry
        for (int k = 0; k < 5; k++) begin
            wdog_kick = 1'b1;
            @(posedge clk); #1;
            wdog_kick = 1'b0;
            push_pt(cyc + 39, 3'b111, 1'b0, 2'b10);
            drain(cyc + 39, 1'b0);
        end
        wdog_enable = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
